// File: rtl/mono_video_filter.sv
// rtl/mono_video_filter.sv - three-stage RGB to monochrome (green/amber/white) video filter
// Mode changes are taken only on a vblank rising edge and travel with each pixel so a frame is never mixed.
module mono_video_filter #(
    parameter int unsigned W_R = 54,
    parameter int unsigned W_G = 183,
    parameter int unsigned W_B = 18
) (
    input  logic       clk_vga,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic [5:0] r_in,
    input  logic [5:0] g_in,
    input  logic [5:0] b_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       hblank_in,
    input  logic       vblank_in,
    input  logic [1:0] mode_req,
    output logic [5:0] r_out,
    output logic [5:0] g_out,
    output logic [5:0] b_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       hblank_out,
    output logic       vblank_out,
    output logic [1:0] mode_active,
    output logic       mode_pending
);

    localparam logic [13:0] WR14 = 14'(W_R);
    localparam logic [13:0] WG14 = 14'(W_G);
    localparam logic [13:0] WB14 = 14'(W_B);

    // timing vectors are packed as {hsync, vsync, hblank, vblank}
    logic [5:0] r1_q, g1_q, b1_q;
    logic [3:0] tim1_q;
    logic [1:0] mode1_q;

    logic [5:0] r2_q, g2_q, b2_q, y2_q;
    logic [3:0] tim2_q;
    logic [1:0] mode2_q;

    logic [5:0] r3_q, g3_q, b3_q;
    logic [3:0] tim3_q;
    logic [1:0] mode_active_q;

    logic        mode_load;
    logic [1:0]  mode_sel_d;
    logic [13:0] luma_sum_d;
    logic [5:0]  y_d;
    logic        blank_d;
    logic [5:0]  r_d, g_d, b_d;

    // vblank rising edge is judged against the S1-registered copy of vblank
    assign mode_load  = vblank_in & ~tim1_q[0];
    assign mode_sel_d = mode_load ? mode_req : mode_active_q;

    assign luma_sum_d = WR14 * {8'd0, r1_q} + WG14 * {8'd0, g1_q} + WB14 * {8'd0, b1_q};
    assign y_d        = 6'(luma_sum_d >> 8);

    always_comb begin
        blank_d = tim2_q[1] | tim2_q[0];
        r_d = r2_q;
        g_d = g2_q;
        b_d = b2_q;
        case (mode2_q)
            2'b00: ;
            2'b01: begin
                r_d = 6'd0;
                g_d = y2_q;
                b_d = 6'd0;
            end
            2'b10: begin
                r_d = y2_q;
                g_d = {1'b0, y2_q[5:1]};
                b_d = 6'd0;
            end
            default: begin
                r_d = y2_q;
                g_d = y2_q;
                b_d = y2_q;
            end
        endcase
        if (blank_d) begin
            r_d = 6'd0;
            g_d = 6'd0;
            b_d = 6'd0;
        end
    end

    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            r1_q          <= 6'd0;
            g1_q          <= 6'd0;
            b1_q          <= 6'd0;
            tim1_q        <= 4'd0;
            mode1_q       <= 2'd0;
            r2_q          <= 6'd0;
            g2_q          <= 6'd0;
            b2_q          <= 6'd0;
            y2_q          <= 6'd0;
            tim2_q        <= 4'd0;
            mode2_q       <= 2'd0;
            r3_q          <= 6'd0;
            g3_q          <= 6'd0;
            b3_q          <= 6'd0;
            tim3_q        <= 4'd0;
            mode_active_q <= 2'd0;
        end else if (ce_pix) begin
            r1_q          <= r_in;
            g1_q          <= g_in;
            b1_q          <= b_in;
            tim1_q        <= {hsync_in, vsync_in, hblank_in, vblank_in};
            mode1_q       <= mode_sel_d;
            mode_active_q <= mode_sel_d;

            r2_q    <= r1_q;
            g2_q    <= g1_q;
            b2_q    <= b1_q;
            y2_q    <= y_d;
            tim2_q  <= tim1_q;
            mode2_q <= mode1_q;

            r3_q   <= r_d;
            g3_q   <= g_d;
            b3_q   <= b_d;
            tim3_q <= tim2_q;
        end
    end

    assign r_out        = r3_q;
    assign g_out        = g3_q;
    assign b_out        = b3_q;
    assign hsync_out    = tim3_q[3];
    assign vsync_out    = tim3_q[2];
    assign hblank_out   = tim3_q[1];
    assign vblank_out   = tim3_q[0];
    assign mode_active  = mode_active_q;
    assign mode_pending = (mode_req != mode_active_q);

endmodule

// File: tb/tb_mono_video_filter.sv
// tb/tb_mono_video_filter.sv - randomized and directed checks of mono_video_filter against a queue-based model
module tb_mono_video_filter;

    localparam int W_R = 54;
    localparam int W_G = 183;
    localparam int W_B = 18;

    logic       clk_vga = 1'b0;
    logic       reset   = 1'b1;
    logic       ce_pix  = 1'b0;
    logic [5:0] r_in = '0, g_in = '0, b_in = '0;
    logic       hsync_in = 1'b0, vsync_in = 1'b0, hblank_in = 1'b0, vblank_in = 1'b0;
    logic [1:0] mode_req = 2'd0;
    logic [5:0] r_out, g_out, b_out;
    logic       hsync_out, vsync_out, hblank_out, vblank_out;
    logic [1:0] mode_active;
    logic       mode_pending;

    mono_video_filter #(.W_R(W_R), .W_G(W_G), .W_B(W_B)) dut (
        .clk_vga(clk_vga), .reset(reset), .ce_pix(ce_pix),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
        .mode_req(mode_req),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblank_out(hblank_out), .vblank_out(vblank_out),
        .mode_active(mode_active), .mode_pending(mode_pending)
    );

    always #5 clk_vga = ~clk_vga;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
    } px_t;

    px_t        pipe_q[$];
    logic [1:0] m_mode    = 2'd0;
    logic       m_prev_vb = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic px_t expect_px(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                                      input logic hs, input logic vs, input logic hb, input logic vb,
                                      input logic [1:0] mode);
        int  y;
        px_t p;
        y = (W_R * int'(r) + W_G * int'(g) + W_B * int'(b)) / 256;
        p.hs = hs; p.vs = vs; p.hb = hb; p.vb = vb;
        case (mode)
            2'd0:    begin p.r = r;      p.g = g;          p.b = b;      end
            2'd1:    begin p.r = 6'd0;   p.g = 6'(y);      p.b = 6'd0;   end
            2'd2:    begin p.r = 6'(y);  p.g = 6'(y / 2);  p.b = 6'd0;   end
            default: begin p.r = 6'(y);  p.g = 6'(y);      p.b = 6'(y);  end
        endcase
        if (hb || vb) begin
            p.r = 6'd0; p.g = 6'd0; p.b = 6'd0;
        end
        return p;
    endfunction

    // model: the output is the pixel accepted three ce edges ago, rendered in the mode in force when it entered
    always @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            pipe_q.delete();
            m_mode    = 2'd0;
            m_prev_vb = 1'b0;
        end else if (ce_pix) begin
            if (vblank_in && !m_prev_vb) m_mode = mode_req;
            m_prev_vb = vblank_in;
            pipe_q.push_back(expect_px(r_in, g_in, b_in, hsync_in, vsync_in, hblank_in, vblank_in, m_mode));
            if (pipe_q.size() > 3) void'(pipe_q.pop_front());
        end
    end

    always @(negedge clk_vga) begin
        px_t e;
        px_t a;
        e = (pipe_q.size() == 3) ? pipe_q[0] : px_t'(0);
        a = {r_out, g_out, b_out, hsync_out, vsync_out, hblank_out, vblank_out};
        chk("pixel_model", int'(a), int'(e));
        chk("mode_active_model", int'(mode_active), int'(m_mode));
        chk("mode_pending_model", int'(mode_pending), int'(mode_req != m_mode));
    end

    task automatic step(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                        input logic hs, input logic vs, input logic hb, input logic vb, input logic ce);
        r_in = r; g_in = g; b_in = b;
        hsync_in = hs; vsync_in = vs; hblank_in = hb; vblank_in = vb;
        ce_pix = ce;
        @(posedge clk_vga);
        #2;
    endtask

    task automatic load_mode(input logic [1:0] m);
        mode_req = m;
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_rgb(input string name, input int r, input int g, input int b);
        chk({name, "_r"}, int'(r_out), r);
        chk({name, "_g"}, int'(g_out), g);
        chk({name, "_b"}, int'(b_out), b);
    endtask

    initial begin
        repeat (3) @(posedge clk_vga);
        #2;
        check_rgb("reset_out", 0, 0, 0);
        chk("reset_mode_active", int'(mode_active), 0);
        reset = 1'b0;

        // white mode, full-scale grey
        load_mode(2'd3);
        chk("white_mode_active", int'(mode_active), 3);
        chk("white_mode_pending", int'(mode_pending), 0);
        step(6'd63, 6'd63, 6'd63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rgb("white_latency2", 0, 0, 0);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rgb("white_62", 62, 62, 62);

        // green mode, pure red
        load_mode(2'd1);
        step(6'd63, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rgb("green_red", 0, 13, 0);

        // amber mode, pure green
        load_mode(2'd2);
        step(6'd0, 6'd63, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rgb("amber_green", 45, 22, 0);

        // mid-frame request stays pending until vblank rises
        load_mode(2'd0);
        mode_req = 2'd3;
        step(6'd10, 6'd20, 6'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pending_set", int'(mode_pending), 1);
        chk("pending_active", int'(mode_active), 0);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rgb("pending_colour", 10, 20, 30);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("pending_loaded", int'(mode_active), 3);
        chk("pending_clear", int'(mode_pending), 0);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // hblank forces black in colour mode
        load_mode(2'd0);
        step(6'd63, 6'd63, 6'd63, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(6'd5, 6'd5, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(6'd5, 6'd5, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rgb("hblank_black", 0, 0, 0);
        chk("hblank_out", int'(hblank_out), 1);

        // ce on every second clock with toggling hsync
        for (int i = 0; i < 40; i++) begin
            step(6'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'(i % 2));
        end

        // asynchronous reset with a full pipeline in amber mode
        load_mode(2'd2);
        for (int i = 0; i < 3; i++) step(6'd40, 6'd50, 6'd60, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        check_rgb("async_rst", 0, 0, 0);
        chk("async_rst_hsync", int'(hsync_out), 0);
        chk("async_rst_mode", int'(mode_active), 0);
        @(posedge clk_vga);
        #2;
        reset = 1'b0;
        step(6'd0, 6'd63, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rgb("post_rst_1", 0, 0, 0);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rgb("post_rst_2", 0, 0, 0);
        step(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_rgb("post_rst_3", 0, 63, 0);

        // randomized traffic with sparse vblank edges, mode requests and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) mode_req = 2'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                @(posedge clk_vga);
                #2;
                reset = 1'b0;
            end
            step(6'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 3) != 0));
        end

        @(negedge clk_vga);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
